// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings, state type and PSR bit positions for the ALU sequencer
package alu_seq_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_MOV  = 8'h0D;

  // Shift class; the 4-bit patterns are opcode-only matches (opext is don't-care)
  localparam logic [7:0] OP_LSH   = 8'h84;
  localparam logic [3:0] OPC_LSHX = 4'h8;
  localparam logic [7:0] OP_RSH   = 8'h0E;
  localparam logic [3:0] OPC_RSHI = 4'hE;
  localparam logic [7:0] OP_SHA1  = 8'hA1;
  localparam logic [7:0] OP_SHA4  = 8'hA4;

  // Add-with-carry class
  localparam logic [7:0] OP_ADDC   = 8'h07;
  localparam logic [3:0] OPC_ADDCI = 4'h7;
  localparam logic [7:0] OP_ADDCU  = 8'hA5;
  localparam logic [7:0] OP_ADDCUI = 8'hA6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - classifies {opcode,opext} into shift and add-with-carry operations
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] opext,
  output logic       is_shift,
  output logic       is_addc
);

  logic [7:0] key;
  assign key = {opcode, opext};

  always_comb begin
    is_shift = 1'b0;
    is_addc  = 1'b0;
    if (key == OP_LSH || opcode == OPC_LSHX || key == OP_RSH || opcode == OPC_RSHI ||
        key == OP_SHA1 || key == OP_SHA4) begin
      is_shift = 1'b1;
    end else if (key == OP_ADDC || opcode == OPC_ADDCI || key == OP_ADDCU || key == OP_ADDCUI) begin
      is_addc = 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle sequencer driving the 16-bit ALU and owning the PSR
// Optional carry-in chaining for add-with-carry ops: define ALU_SEQ_CARRY_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       psr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_opext,
  input  logic [WIDTH-1:0] alu_s,
  input  logic [4:0]       alu_clfzn
);

`ifdef ALU_SEQ_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  state_t           state, state_nx;
  logic [3:0]       op_code, op_ext;
  logic [WIDTH-1:0] work_a, op_b;
  logic [CNT_W-1:0] pcnt;
  logic             carry_mode, pass1_c, pass1_f;
  logic             is_shift, is_addc;
  logic [CNT_W-1:0] shamt;

  assign shamt = b[CNT_W-1:0];

  alu_seq_decode u_decode (
    .opcode  (opcode),
    .opext   (opext),
    .is_shift(is_shift),
    .is_addc (is_addc)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = EXEC;
      EXEC:    if (pcnt == CNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_code    <= 4'h0;
      op_ext     <= 4'h0;
      work_a     <= '0;
      op_b       <= '0;
      pcnt       <= '0;
      carry_mode <= 1'b0;
      pass1_c    <= 1'b0;
      pass1_f    <= 1'b0;
      result     <= '0;
      psr        <= 5'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          work_a     <= a;
          op_b       <= b;
          op_code    <= opcode;
          op_ext     <= opext;
          carry_mode <= 1'b0;
          pcnt       <= CNT_W'(1);
          // A zero-length shift becomes a single MOV pass so the result is A
          if (is_shift && shamt == '0) begin
            {op_code, op_ext} <= OP_MOV;
          end else if (is_shift) begin
            pcnt <= shamt;
          end else if (CARRY_EN && is_addc && psr[PSR_C]) begin
            carry_mode <= 1'b1;
            pcnt       <= CNT_W'(2);
          end
        end
        EXEC: begin
          work_a <= alu_s;
          pcnt   <= pcnt - 1'b1;
          if (carry_mode && pcnt == CNT_W'(2)) begin
            pass1_c <= alu_clfzn[PSR_C];
            pass1_f <= alu_clfzn[PSR_F];
          end
          if (pcnt == CNT_W'(1)) begin
            result <= alu_s;
            if (carry_mode) begin
              psr <= {pass1_c | alu_clfzn[PSR_C], 1'b0, pass1_f, alu_clfzn[PSR_Z], 1'b0};
            end else begin
              psr <= alu_clfzn;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = 4'h0;
    alu_opext  = 4'h0;
    if (state == EXEC) begin
      alu_a                 = work_a;
      alu_b                 = op_b;
      {alu_opcode, alu_opext} = {op_code, op_ext};
      // Second pass of a carried add folds the carry in as +1
      if (carry_mode && pcnt == CNT_W'(1)) begin
        alu_b                 = WIDTH'(1);
        {alu_opcode, alu_opext} = OP_ADDU;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl with a stand-in ALU model
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [3:0]  opcode, opext;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result;
  logic [4:0]  psr;
  logic [15:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_opcode, alu_opext;
  logic [4:0]  alu_clfzn;

  int checks = 0;
  int failures = 0;
  logic [4:0]  m_psr;
  logic [15:0] last_res;
  logic [4:0]  last_psr;
  int          last_lat;
  logic [7:0]  key;
  logic [7:0]  tbl [12] = '{8'h84, 8'h80, 8'h0E, 8'hE0, 8'hA1, 8'hA4,
                            8'h06, 8'h07, 8'h70, 8'hA5, 8'hA6, 8'h0D};

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .opext(opext),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .psr(psr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_opext(alu_opext),
    .alu_s(alu_s), .alu_clfzn(alu_clfzn)
  );

  // Stand-in ALU: returns {C,L,F,Z,N,S}
  function automatic logic [20:0] alu_m(input logic [3:0] oc, input logic [3:0] oe,
                                        input logic [15:0] x, input logic [15:0] y);
    logic [16:0] sum;
    logic [15:0] s;
    logic        c, f;
    c = 1'b0;
    f = 1'b0;
    sum = {1'b0, x} + {1'b0, y};
    casez ({oc, oe})
      8'b0000_0110, 8'b0000_0111, 8'b0111_????, 8'b1010_0101, 8'b1010_0110: begin
        s = sum[15:0];
        c = sum[16];
        f = (x[15] == y[15]) && (s[15] != x[15]);
      end
      8'b0000_1101: s = x;
      8'b1000_????: begin s = {x[14:0], 1'b0}; c = x[15]; end
      8'b0000_1110, 8'b1110_????, 8'b1010_0001, 8'b1010_0100: begin
        s = {1'b0, x[15:1]};
        c = x[0];
      end
      default: s = x ^ y;
    endcase
    return {c, 1'b0, f, (s == 16'h0), s[15], s};
  endfunction

  always_comb {alu_clfzn, alu_s} = alu_m(alu_opcode, alu_opext, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result/flags/pass count straight from the operation rules
  task automatic model(input logic [3:0] oc, input logic [3:0] oe, input logic [15:0] av,
                       input logic [15:0] bv, output logic [15:0] r, output logic [4:0] pf,
                       output int p);
    logic [20:0] o1, o2;
    logic [7:0]  k;
    bit          shift, addc;
    k = {oc, oe};
    shift = (oc == 4'h8) || (oc == 4'hE) || (k == 8'h0E) || (k == 8'hA1) || (k == 8'hA4);
    addc  = (oc == 4'h7) || (k == 8'h07) || (k == 8'hA5) || (k == 8'hA6);
    if (shift) begin
      p = int'(bv[3:0]);
      if (p == 0) begin
        p  = 1;
        o1 = alu_m(4'h0, 4'hD, av, bv);
      end else begin
        o1 = {5'b0, av};
        for (int i = 0; i < p; i++) o1 = alu_m(oc, oe, o1[15:0], bv);
      end
      r  = o1[15:0];
      pf = o1[20:16];
    end else if (addc && CARRY && m_psr[4]) begin
      p  = 2;
      o1 = alu_m(oc, oe, av, bv);
      o2 = alu_m(4'h0, 4'h6, o1[15:0], 16'd1);
      r  = o2[15:0];
      pf = {o1[20] | o2[20], 1'b0, o1[18], o2[17], 1'b0};
    end else begin
      p  = 1;
      o1 = alu_m(oc, oe, av, bv);
      r  = o1[15:0];
      pf = o1[20:16];
    end
    m_psr = pf;
  endtask

  task automatic run_op(input logic [3:0] oc, input logic [3:0] oe, input logic [15:0] av,
                        input logic [15:0] bv, input logic [7:0] code, input bit chk_code);
    logic [15:0] er;
    logic [4:0]  ep;
    int p, edges, execs, hits;
    model(oc, oe, av, bv, er, ep, p);
    @(negedge clk);
    start = 1'b1; opcode = oc; opext = oe; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; opcode = 4'($urandom); opext = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    edges = 0; execs = 0; hits = 0;
    while (!done && edges < 40) begin
      if (busy) execs++;
      if ({alu_opcode, alu_opext} == code) hits++;
      @(posedge clk); #1;
      edges++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", edges + 1, p + 1);
    check("exec_cycles", execs, p);
    if (chk_code) check("alu_code_cycles", hits, p);
    check("result", 32'(result), 32'(er));
    check("psr", 32'(psr), 32'(ep));
    last_res = result; last_psr = psr; last_lat = edges + 1;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_held", 32'(result), 32'(er));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    reset_n = 1'b0; start = 1'b0; opcode = '0; opext = '0; a = '0; b = '0;
    m_psr = '0; last_res = '0; last_psr = '0; last_lat = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_psr", 32'(psr), 32'd0);
    check("idle_alu", {alu_opcode, alu_opext, alu_a}, 32'd0);
    @(negedge clk) reset_n = 1'b1;

    run_op(4'h8, 4'h4, 16'h0001, 16'h0004, 8'h84, 1'b1);
    check("lsh_lat", last_lat, 5);
    check("lsh_res", 32'(last_res), 32'h0010);
    check("lsh_psr", 32'(last_psr), 32'd0);

    run_op(4'hE, 4'h0, 16'h8000, 16'h0000, 8'h0D, 1'b1);
    check("rshi0_lat", last_lat, 2);
    check("rshi0_res", 32'(last_res), 32'h8000);

    run_op(4'h0, 4'h6, 16'hFFFF, 16'h0001, 8'h06, 1'b1);
    check("addu_lat", last_lat, 2);
    check("addu_res", 32'(last_res), 32'h0000);
    check("addu_psr", 32'(last_psr), 32'b10010);

    run_op(4'h0, 4'h7, 16'h0001, 16'h0001, 8'h00, 1'b0);
    check("addc_res", 32'(last_res), CARRY ? 32'h0003 : 32'h0002);
    check("addc_lat", last_lat, CARRY ? 3 : 2);

    begin
      logic [15:0] er;
      logic [4:0]  ep;
      int p;
      model(4'h8, 4'h4, 16'h0001, 16'h000F, er, ep, p);
      @(negedge clk);
      start = 1'b1; opcode = 4'h8; opext = 4'h4; a = 16'h0001; b = 16'h000F;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        if (i == 9) start = 1'b0;
        if (done) begin
          dones++;
          check("held_done_at", i, p);
          check("held_result", 32'(result), 32'(er));
        end
      end
      check("held_done_count", dones, 1);
      check("held_idle_after", 32'(busy), 32'd0);
    end

    @(negedge clk);
    start = 1'b1; opcode = 4'h8; opext = 4'h4; a = 16'h0001; b = 16'h0008;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    m_psr = '0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_psr", 32'(psr), 32'd0);
    check("midrst_alu", {alu_opcode, alu_opext, alu_a}, 32'd0);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);

    for (int n = 0; n < 25; n++) begin
      key = tbl[$urandom_range(0, 11)];
      if ((key[7:4] == 4'h8 || key[7:4] == 4'h7 || key[7:4] == 4'hE) && key != 8'h84)
        key[3:0] = 4'($urandom);
      if ($urandom_range(0, 3) == 0) key = 8'($urandom);
      run_op(key[7:4], key[3:0], 16'($urandom), 16'($urandom), 8'h00, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
